instr_fetch_unit: RTL and testbench

Fetch stage feeding the decode/execute datapath in the pipelined CPU. It replaces the bare program counter, PC+4 adder and combinational instruction memory pairing with a fetch engine. The engine owns the fetch PC and talks to a multi-cycle instruction memory over a req/ack handshake. Fetched words are buffered in a small prefetch FIFO and presented with their PC and PC+4 to the downstream stage under valid/ready. Branch, jump, jal and jr targets arrive as a redirect that flushes the buffer.

---
 rtl/ifu_pkg.sv | 21 ++
 rtl/ifu_fifo.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int          INSTR_W  = 32;
  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  // FETCH: normal operation. DISCARD: the one outstanding response belongs to
  // a pre-redirect address and must be dropped when it returns.
  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } ifu_state_t;

  // One prefetch buffer entry: the instruction word and the PC it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Show-ahead prefetch FIFO holding {instr, pc} entries, with synchronous flush.
// The head entry is visible on rdata whenever empty is low.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  output fetch_entry_t  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Entry storage write port.
  // NOTE: the storage array has no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
  // NOTE: state flops take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues single-outstanding requests to a
// multi-cycle instruction memory, buffers returned words in a prefetch FIFO
// and presents {instr, pc, pc+4} downstream under valid/ready.
// Optional build macro IFU_PERF_CNT_EN enables the fetch/flush counters;
// without it both counter ports are constant zero.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int CW = $clog2(DEPTH + 1);

  ifu_state_t    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_inc;
  logic [31:0]   redirect_target;
  logic          ack_accept;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ_after;
  logic          credit_ok;
  fetch_entry_t  head;

  assign pc_inc          = fetch_pc + PC_STEP;
  assign redirect_target = redirect_pc_i & ~32'd3;
  assign ack_accept      = imem_req_o & imem_ack_i;

  // Redirect cancels both the push of a coincident ack and any pop.
  assign pop  = instr_valid_o & instr_ready_i & ~redirect_i;
  assign push = ack_accept & (state == FETCH) & ~redirect_i & (~fifo_full | pop);

  // Credit looks at occupancy after this cycle's push/pop, so a draining full
  // FIFO keeps fetching back-to-back.
  assign occ_after = {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop);
  assign credit_ok = occ_after < (CW+1)'(DEPTH);

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .flush (redirect_i),
    .push  (push),
    .wdata ('{instr: imem_data_i, pc: fetch_pc}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head entry is gated to zero while empty so the outputs are defined.
  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = instr_valid_o ? head.instr         : NOP_WORD;
  assign pc_o          = instr_valid_o ? head.pc            : '0;
  assign pc_plus4_o    = instr_valid_o ? head.pc + PC_STEP  : '0;

  // Fetch control: state, fetch PC and the registered memory request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_target;
      if (imem_req_o && !imem_ack_i) begin
        // Old request still in flight: keep it stable and drop its response.
        state <= DISCARD;
      end else begin
        state      <= FETCH;
        imem_req_o <= 1'b0;
      end
    end else if (state == DISCARD) begin
      if (imem_ack_i) begin
        state      <= FETCH;
        imem_req_o <= 1'b0;
      end
    end else begin
      if (push) fetch_pc <= pc_inc;
      if (!imem_req_o || imem_ack_i) begin
        imem_req_o <= credit_ok;
        if (credit_ok) imem_addr_o <= push ? pc_inc : fetch_pc;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic        drop_ack;
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  assign drop_ack = ack_accept & (redirect_i | (state == DISCARD));

  // Performance counters: pushes, and entries/responses thrown away.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      flush_cnt_q <= flush_cnt_q
                   + (redirect_i ? 32'(fifo_count) : 32'd0)
                   + 32'(drop_ack);
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign fetch_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run checked against a program-order PC model and a memory
// whose contents are a fixed function of the address.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] flush_cnt_o;

  int unsigned checks = 0;
  int unsigned passes = 0;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: acks after cur_lat wait cycles, optionally acks spuriously
  // while no request is pending. Drives on the falling edge.
  int unsigned mem_lat_min = 0;
  int unsigned mem_lat_max = 0;
  int unsigned cur_lat = 0;
  int unsigned waited = 0;
  bit          mem_spurious = 1'b0;

  always @(negedge clk) begin
    if (imem_req_o) begin
      if (waited >= cur_lat) begin
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word(imem_addr_o);
        waited      = 0;
        cur_lat     = $urandom_range(mem_lat_max, mem_lat_min);
      end else begin
        imem_ack_i  = 1'b0;
        imem_data_i = $urandom;
        waited      = waited + 1;
      end
    end else begin
      waited = 0;
      if (mem_spurious && ($urandom_range(3) == 0)) begin
        imem_ack_i  = 1'b1;
        imem_data_i = $urandom;
      end else begin
        imem_ack_i  = 1'b0;
      end
    end
  end

  task automatic set_mem(input int unsigned lo, input int unsigned hi, input bit spur);
    mem_lat_min  = lo;
    mem_lat_max  = hi;
    cur_lat      = lo;
    waited       = 0;
    mem_spurious = spur;
  endtask

  // Sample point: just after the falling edge, clear of the rising edge.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Hold reset for a few cycles, release on a falling edge. The next tick()
  // samples the cycle after the first active edge.
  task automatic do_reset();
    rst_i      = 1'b0;
    redirect_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    set_mem(0, 0, 1'b0);
    instr_ready_i = 1'b0;
    rst_i = 1'b0;
    repeat (2) tick();
    checks++;
    if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
         fetch_cnt_o, flush_cnt_o} !== '0)
      $display("FAIL reset_outputs req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h fc=%h flc=%h",
               imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
               fetch_cnt_o, flush_cnt_o);
    else passes++;
    @(negedge clk);
    rst_i = 1'b1;
    tick();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0)
      $display("FAIL reset_first_req req=%b addr=%h want req=1 addr=00000000", imem_req_o, imem_addr_o);
    else passes++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    set_mem(0, 0, 1'b0);
    instr_ready_i = 1'b1;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * (c - 1)))
        $display("FAIL zw_req c=%0d req=%b addr=%h want addr=%h", c, imem_req_o, imem_addr_o, 32'(4 * (c - 1)));
      else passes++;
      if (c >= 2) begin
        exp_pc = 32'(4 * (c - 2));
        checks++;
        if (instr_valid_o !== 1'b1 || pc_o !== exp_pc || instr_o !== mem_word(exp_pc) || pc_plus4_o !== exp_pc + 32'd4)
          $display("FAIL zw_out c=%0d valid=%b pc=%h instr=%h pc4=%h want pc=%h instr=%h",
                   c, instr_valid_o, pc_o, instr_o, pc_plus4_o, exp_pc, mem_word(exp_pc));
        else passes++;
      end else begin
        checks++;
        if (instr_valid_o !== 1'b0)
          $display("FAIL zw_first_valid c=%0d valid=%b want 0", c, instr_valid_o);
        else passes++;
      end
    end
    checks++;
`ifdef IFU_PERF_CNT_EN
    if (fetch_cnt_o !== 32'd7) $display("FAIL zw_fetch_cnt got=%0d want=7", fetch_cnt_o);
`else
    if (fetch_cnt_o !== 32'd0) $display("FAIL zw_fetch_cnt got=%0d want=0", fetch_cnt_o);
`endif
    else passes++;
  endtask

  task automatic test_full_stall();
    int nreq = 0;
    set_mem(0, 0, 1'b0);
    instr_ready_i = 1'b0;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (imem_req_o === 1'b1) nreq++;
      checks++;
      if (imem_req_o !== (c <= 4) || (c <= 4 && imem_addr_o !== 32'(4 * (c - 1))))
        $display("FAIL stall_req c=%0d req=%b addr=%h want req=%b addr=%h",
                 c, imem_req_o, imem_addr_o, (c <= 4), 32'(4 * (c - 1)));
      else passes++;
      if (c >= 5) begin
        checks++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h0)
          $display("FAIL stall_hold c=%0d valid=%b pc=%h want pc=0", c, instr_valid_o, pc_o);
        else passes++;
      end
    end
    checks++;
    if (nreq != 4) $display("FAIL stall_nreq got=%0d want=4", nreq);
    else passes++;
    instr_ready_i = 1'b1;
    tick();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || pc_o !== 32'h4)
      $display("FAIL stall_resume req=%b addr=%h pc=%h want req=1 addr=10 pc=4", imem_req_o, imem_addr_o, pc_o);
    else passes++;
  endtask

  task automatic test_redirect_discard();
    bit found = 1'b0;
    bit seen  = 1'b0;
    set_mem(3, 3, 1'b0);
    instr_ready_i = 1'b1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (imem_req_o === 1'b1 && imem_addr_o === 32'h8) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) $display("FAIL disc_find_req8 got=none want request to 00000008");
    else passes++;
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || instr_valid_o !== 1'b0)
      $display("FAIL disc_hold req=%b addr=%h valid=%b want req=1 addr=8 valid=0",
               imem_req_o, imem_addr_o, instr_valid_o);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(imem_req_o === 1'b1 && imem_addr_o === 32'h8)) break;
    end
    for (int i = 0; i < 10 && imem_req_o !== 1'b1; i++) tick();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40)
      $display("FAIL disc_next_req req=%b addr=%h want req=1 addr=40", imem_req_o, imem_addr_o);
    else passes++;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen || pc_o !== 32'h40 || instr_o !== mem_word(32'h40))
      $display("FAIL disc_first_out seen=%b pc=%h instr=%h want pc=40 instr=%h",
               seen, pc_o, instr_o, mem_word(32'h40));
    else passes++;
    checks++;
`ifdef IFU_PERF_CNT_EN
    if (fetch_cnt_o !== 32'd3 || flush_cnt_o !== 32'd1)
      $display("FAIL disc_counters fc=%0d flc=%0d want fc=3 flc=1", fetch_cnt_o, flush_cnt_o);
`else
    if (fetch_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0)
      $display("FAIL disc_counters fc=%0d flc=%0d want 0 0", fetch_cnt_o, flush_cnt_o);
`endif
    else passes++;
  endtask

  task automatic test_redirect_ack_pop();
    set_mem(0, 0, 1'b0);
    instr_ready_i = 1'b1;
    do_reset();
    repeat (4) tick();
    checks++;
    if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b1 || imem_ack_i !== 1'b1 || pc_o !== 32'h8)
      $display("FAIL rap_setup valid=%b req=%b ack=%b pc=%h want 1 1 1 pc=8",
               instr_valid_o, imem_req_o, imem_ack_i, pc_o);
    else passes++;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h103;
    tick();
    redirect_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0)
      $display("FAIL rap_flush valid=%b req=%b want 0 0", instr_valid_o, imem_req_o);
    else passes++;
    checks++;
`ifdef IFU_PERF_CNT_EN
    if (fetch_cnt_o !== 32'd3 || flush_cnt_o !== 32'd2)
      $display("FAIL rap_counters fc=%0d flc=%0d want fc=3 flc=2", fetch_cnt_o, flush_cnt_o);
`else
    if (fetch_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0)
      $display("FAIL rap_counters fc=%0d flc=%0d want 0 0", fetch_cnt_o, flush_cnt_o);
`endif
    else passes++;
    tick();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100)
      $display("FAIL rap_new_req req=%b addr=%h want req=1 addr=100", imem_req_o, imem_addr_o);
    else passes++;
    tick();
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== mem_word(32'h100))
      $display("FAIL rap_out valid=%b pc=%h instr=%h want pc=100 instr=%h",
               instr_valid_o, pc_o, instr_o, mem_word(32'h100));
    else passes++;
  endtask

  task automatic test_wrap();
    bit seen = 1'b0;
    set_mem(0, 0, 1'b0);
    instr_ready_i = 1'b0;
    do_reset();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (instr_valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0 || instr_o !== mem_word(32'hFFFF_FFFC))
      $display("FAIL wrap_out seen=%b pc=%h pc4=%h instr=%h want pc=fffffffc pc4=0 instr=%h",
               seen, pc_o, pc_plus4_o, instr_o, mem_word(32'hFFFF_FFFC));
    else passes++;
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0)
      $display("FAIL wrap_next_req req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o);
    else passes++;
    instr_ready_i = 1'b1;
    tick();
    checks++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || pc_plus4_o !== 32'h4 || instr_o !== mem_word(32'h0))
      $display("FAIL wrap_second valid=%b pc=%h pc4=%h instr=%h want pc=0 pc4=4",
               instr_valid_o, pc_o, pc_plus4_o, instr_o);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    set_mem(3, 3, 1'b0);
    instr_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (instr_valid_o === 1'b1 && imem_req_o === 1'b1 && imem_ack_i === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) $display("FAIL rmid_setup got=no pending request want valid+pending request");
    else passes++;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    #1 rst_i = 1'b0;
    #1;
    checks++;
    if ({imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
         fetch_cnt_o, flush_cnt_o} !== '0)
      $display("FAIL rmid_async req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h fc=%h flc=%h",
               imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
               fetch_cnt_o, flush_cnt_o);
    else passes++;
    repeat (2) tick();
    redirect_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    tick();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || instr_valid_o !== 1'b0 ||
        fetch_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0)
      $display("FAIL rmid_restart req=%b addr=%h valid=%b fc=%0d flc=%0d want req=1 addr=0 valid=0 fc=0 flc=0",
               imem_req_o, imem_addr_o, instr_valid_o, fetch_cnt_o, flush_cnt_o);
    else passes++;
  endtask

  // Randomized run: the delivered stream must follow program order from
  // RESET_PC or the latest redirect target, with words matching memory.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] prev_addr = '0;
    logic [31:0] target;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    bit          prev_redir = 1'b0;
    bit          redir;
    int          consumed = 0;
    set_mem(0, 3, 1'b1);
    instr_ready_i = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      redirect_i = 1'b0;
      if (prev_req && !prev_ack) begin
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== prev_addr)
          $display("FAIL rnd_addr_stable cyc=%0d req=%b addr=%h want req=1 addr=%h",
                   cyc, imem_req_o, imem_addr_o, prev_addr);
        else passes++;
      end
      if (prev_redir) begin
        checks++;
        if (instr_valid_o !== 1'b0)
          $display("FAIL rnd_flush cyc=%0d valid=%b want 0", cyc, instr_valid_o);
        else passes++;
      end
      checks++;
      if (instr_valid_o === 1'b1) begin
        if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc) || pc_plus4_o !== exp_pc + 32'd4)
          $display("FAIL rnd_out cyc=%0d pc=%h instr=%h pc4=%h want pc=%h instr=%h",
                   cyc, pc_o, instr_o, pc_plus4_o, exp_pc, mem_word(exp_pc));
        else passes++;
      end else begin
        if (instr_valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== 32'h0 || pc_plus4_o !== 32'h0)
          $display("FAIL rnd_idle cyc=%0d valid=%b pc=%h instr=%h pc4=%h want all 0",
                   cyc, instr_valid_o, pc_o, instr_o, pc_plus4_o);
        else passes++;
      end
      prev_req  = imem_req_o;
      prev_ack  = imem_ack_i;
      prev_addr = imem_addr_o;
      instr_ready_i = ($urandom_range(3) != 0);
      redir  = ($urandom_range(19) == 0);
      target = $urandom;
      if (redir) begin
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        exp_pc        = target & ~32'd3;
      end else if (instr_valid_o && instr_ready_i) begin
        exp_pc   = exp_pc + 32'd4;
        consumed++;
      end
      prev_redir = redir;
    end
    tick();
    redirect_i = 1'b0;
    checks++;
    if (consumed < 200) $display("FAIL rnd_progress consumed=%0d want >=200", consumed);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_full_stall();
    test_redirect_discard();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
